// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch control. Synchronizes and debounces the start/stop
//               and lap/clear buttons, turns accepted presses into one-cycle
//               events and runs the IDLE/RUN/LAP/STOP state machine that
//               drives the BCD counter enables, clear pulse and lap display.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        i_rtcclk,
  input  logic        rst,
  input  logic        i_startstop,
  input  logic        i_lap,
  input  logic [23:0] i_count,
  output logic        o_countenb,
  output logic        o_latchcount,
  output logic        o_countinit,
  output logic [23:0] o_display,
  output logic [1:0]  o_state,
  output logic        o_lap_valid
);

  localparam int               CNT_W    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  // Bit 0 is start/stop, bit 1 is lap/clear.
  logic [1:0] btn_raw;
  logic [1:0] btn_evt;

  assign btn_raw = {i_lap, i_startstop};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic             deb_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge i_rtcclk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[b];
        sync2_q <= sync1_q;
      end
    end

    // Accept a new level only after it has differed for DEBOUNCE_TICKS cycles.
    always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync2_q != deb_q) begin
        if (cnt_q == CNT_LAST) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Debounce counter, debounced level and its one-cycle-old copy.
    always_ff @(posedge i_rtcclk or posedge rst) begin
      if (rst) begin
        cnt_q      <= '0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        deb_q      <= deb_d;
        deb_prev_q <= deb_q;
      end
    end

    // Only the rising edge of the debounced level is an event.
    assign btn_evt[b] = deb_q & ~deb_prev_q;
  end

  state_t      state_q;
  state_t      state_d;
  logic        en_q;
  logic        en_d;
  logic        init_q;
  logic        init_d;
  logic [23:0] lap_q;
  logic [23:0] lap_d;

  // Next state; start beats lap when both arrive in the same cycle.
  always_comb begin
    state_d = state_q;
    init_d  = 1'b0;
    lap_d   = lap_q;
    if (btn_evt[0]) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = STOP;
        LAP:     state_d = STOP;
        STOP:    state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (btn_evt[1]) begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
          init_d  = 1'b1;
        end
        RUN: begin
          state_d = LAP;
          lap_d   = i_count;
        end
        LAP: begin
          state_d = RUN;
        end
        STOP: begin
          state_d = IDLE;
          init_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    en_d = (state_d == RUN) || (state_d == LAP);
  end

  // State, counter enables, clear pulse and lap register.
  always_ff @(posedge i_rtcclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      init_q  <= 1'b0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      init_q  <= init_d;
      lap_q   <= lap_d;
    end
  end

  assign o_countenb   = en_q;
  assign o_latchcount = en_q;
  assign o_countinit  = init_q;
  assign o_state      = state_q;
  assign o_lap_valid  = (state_q == LAP);
  assign o_display    = (state_q == LAP) ? lap_q : i_count;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl. Directed scenarios
//               followed by randomized button activity, compared every cycle
//               against a window-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int D    = 4;
  localparam int HMAX = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss  = 1'b0;
  logic        lp  = 1'b0;
  logic [23:0] cnt = 24'h0;
  logic        o_countenb;
  logic        o_latchcount;
  logic        o_countinit;
  logic [23:0] o_display;
  logic [1:0]  o_state;
  logic        o_lap_valid;

  stopwatch_ctrl #(.DEBOUNCE_TICKS(D)) dut (
    .i_rtcclk    (clk),
    .rst         (rst),
    .i_startstop (ss),
    .i_lap       (lp),
    .i_count     (cnt),
    .o_countenb  (o_countenb),
    .o_latchcount(o_latchcount),
    .o_countinit (o_countinit),
    .o_display   (o_display),
    .o_state     (o_state),
    .o_lap_valid (o_lap_valid)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int init_seen = 0;

  // Reference model: raw button samples per edge since reset, accepted
  // levels, pending-event flags and the stopwatch mode.
  bit          raw_h [2][HMAX];
  int          k;
  bit          m_deb  [2];
  bit          m_pend [2];
  int          m_state;
  logic [23:0] m_lap;
  bit          m_init;
  bit          cnt_free;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Level seen by the debouncer at edge j: the raw sample two edges earlier.
  function automatic bit din(input int b, input int j);
    if (j < 3) return 1'b0;
    return raw_h[b][j-2];
  endfunction

  task automatic model_reset();
    k       = 0;
    m_state = 0;
    m_lap   = '0;
    m_init  = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_deb[b]  = 1'b0;
      m_pend[b] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit ev [2];
    bit all;
    k++;
    raw_h[0][k] = ss;
    raw_h[1][k] = lp;
    for (int b = 0; b < 2; b++) begin
      ev[b]     = m_pend[b];
      m_pend[b] = 1'b0;
      all = 1'b1;
      for (int i = 0; i < D; i++)
        if (din(b, k - i) == m_deb[b]) all = 1'b0;
      if (all) begin
        m_deb[b] = ~m_deb[b];
        if (m_deb[b]) m_pend[b] = 1'b1;
      end
    end
    m_init = 1'b0;
    if (ev[0]) begin
      case (m_state)
        0: m_state = 1;
        1: m_state = 3;
        2: m_state = 3;
        default: m_state = 1;
      endcase
    end else if (ev[1]) begin
      case (m_state)
        0: m_init = 1'b1;
        1: begin m_state = 2; m_lap = cnt; end
        2: m_state = 1;
        default: begin m_state = 0; m_init = 1'b1; end
      endcase
    end
  endtask

  task automatic compare_all();
    logic [23:0] exp_disp;
    bit          run_like;
    exp_disp = (m_state == 2) ? m_lap : cnt;
    run_like = (m_state == 1) || (m_state == 2);
    check("state",      32'(o_state),      32'(m_state));
    check("countenb",   32'(o_countenb),   32'(run_like));
    check("latchcount", 32'(o_latchcount), 32'(run_like));
    check("countinit",  32'(o_countinit),  32'(m_init));
    check("lap_valid",  32'(o_lap_valid),  32'(m_state == 2));
    check("display",    32'(o_display),    32'(exp_disp));
    if (o_countinit) init_seen++;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_all();
    if (cnt_free) cnt = 24'($urandom);
  endtask

  task automatic press(input bit s, input bit l, input int hold);
    ss = s;
    lp = l;
    repeat (hold) cyc();
    ss = 1'b0;
    lp = 1'b0;
    repeat (8) cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  rem0;
    int  rem1;
    bit  lv0;
    bit  lv1;
    rem0 = 0;
    rem1 = 0;
    lv0  = 1'b0;
    lv1  = 1'b0;
    model_reset();
    cnt_free = 1'b1;

    // Reset state.
    repeat (3) cyc();
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_countenb", 32'(o_countenb), 32'd0);

    // Held start: state and latchcount change on edge D+3.
    rst = 1'b0;
    ss  = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      if (e == D + 2) begin
        check("pre_latency_state", 32'(o_state), 32'd0);
        check("pre_latency_latch", 32'(o_latchcount), 32'd0);
      end
      if (e == D + 3) begin
        check("latency_state", 32'(o_state), 32'd1);
        check("latency_latch", 32'(o_latchcount), 32'd1);
      end
    end
    ss = 1'b0;
    repeat (8) cyc();

    // Bounce 1-0-1-0 with single-cycle pulses: ignored.
    ss = 1'b1; cyc();
    ss = 1'b0; cyc();
    ss = 1'b1; cyc();
    ss = 1'b0;
    repeat (8) cyc();
    check("bounce_state", 32'(o_state), 32'd1);
    check("bounce_latch", 32'(o_latchcount), 32'd1);

    // Lap capture and hold while the count advances, then back to RUN.
    cnt_free = 1'b0;
    cnt      = 24'h012345;
    press(1'b0, 1'b1, 6);
    cnt_free = 1'b1;
    repeat (5) cyc();
    check("lap_state", 32'(o_state), 32'd2);
    check("lap_display", 32'(o_display), 32'h012345);
    check("lap_valid_hi", 32'(o_lap_valid), 32'd1);
    press(1'b0, 1'b1, 6);
    #1;
    check("unlap_state", 32'(o_state), 32'd1);
    check("unlap_display", 32'(o_display), 32'(cnt));

    // RUN -> STOP -> IDLE with one clear pulse, then lap in IDLE pulses again.
    press(1'b1, 1'b0, 6);
    check("stop_state", 32'(o_state), 32'd3);
    init_seen = 0;
    press(1'b0, 1'b1, 6);
    check("clear_state", 32'(o_state), 32'd0);
    check("clear_pulses", 32'(init_seen), 32'd1);
    init_seen = 0;
    press(1'b0, 1'b1, 6);
    check("idle_clear_state", 32'(o_state), 32'd0);
    check("idle_clear_pulses", 32'(init_seen), 32'd1);

    // Simultaneous start and lap in RUN: start wins.
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b1, 6);
    check("both_state", 32'(o_state), 32'd3);
    check("both_lap_valid", 32'(o_lap_valid), 32'd0);

    // Asynchronous reset in LAP with start held through release.
    press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 6);
    check("pre_arst_state", 32'(o_state), 32'd2);
    init_seen = 0;
    ss = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", 32'(o_state), 32'd0);
    check("arst_countenb", 32'(o_countenb), 32'd0);
    check("arst_latch", 32'(o_latchcount), 32'd0);
    check("arst_countinit", 32'(o_countinit), 32'd0);
    check("arst_lap_valid", 32'(o_lap_valid), 32'd0);
    check("arst_display", 32'(o_display), 32'(cnt));
    repeat (2) cyc();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      if (e == D + 2) check("rel_pre_state", 32'(o_state), 32'd0);
      if (e == D + 3) check("rel_state", 32'(o_state), 32'd1);
    end
    check("arst_no_clear", 32'(init_seen), 32'd0);
    ss = 1'b0;
    repeat (8) cyc();

    // Randomized bouncy buttons with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (rem0 == 0) begin
        lv0  = 1'($urandom_range(0, 1));
        rem0 = $urandom_range(1, 10);
      end
      if (rem1 == 0) begin
        lv1  = 1'($urandom_range(0, 1));
        rem1 = $urandom_range(1, 10);
      end
      rem0--;
      rem1--;
      ss = lv0;
      lp = lv1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_TICKS, default 4, the number of consecutive i_rtcclk cycles a synchronized button must hold a new level before it is accepted (4 x 5 ms = 20 ms).
REQ-002 The block SHALL have port i_rtcclk, input, 1 bit, the clock, one 5 ms tick per rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_startstop, input, 1 bit, the raw start/stop button, asynchronous and bouncy.
REQ-005 The block SHALL have port i_lap, input, 1 bit, the raw lap/clear button, asynchronous and bouncy.
REQ-006 The block SHALL have port i_count, input, 24 bits, the live BCD count mm:ss.hh from the 24-bit BCD counter.
REQ-007 The block SHALL have port o_countenb, output, 1 bit, the counter count enable.
REQ-008 The block SHALL have port o_latchcount, output, 1 bit, the counter advance enable.
REQ-009 The block SHALL have port o_countinit, output, 1 bit, a one-cycle pulse that requests a counter clear.
REQ-010 The block SHALL have port o_display, output, 24 bits, the BCD value to show: the live count or the frozen lap.
REQ-011 The block SHALL have port o_state, output, 2 bits, the FSM state.
REQ-012 The block SHALL have port o_lap_valid, output, 1 bit, high while o_display shows the frozen lap.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose counter runs while the synchronized level differs from the debounced level, clears when they match, and updates the debounced level once the difference has persisted DEBOUNCE_TICKS cycles.
REQ-014 A button event SHALL be a one-cycle pulse on the rising edge of the debounced level; falling edges SHALL produce no event.
REQ-015 Pulses shorter than DEBOUNCE_TICKS cycles after synchronization SHALL produce no event.
REQ-016 Latency: counting the first rising edge that samples a held button high as edge 1, o_state and all registered outputs SHALL change on edge DEBOUNCE_TICKS+3.
REQ-017 The FSM SHALL have states IDLE=2'b00, RUN=2'b01, LAP=2'b10 and STOP=2'b11.
REQ-018 In IDLE: a start event SHALL move to RUN; a lap event SHALL stay in IDLE and pulse o_countinit.
REQ-019 In RUN: a start event SHALL move to STOP; a lap event SHALL move to LAP and capture i_count into the lap register on the same edge.
REQ-020 In LAP: a start event SHALL move to STOP, discarding the lap; a lap event SHALL move to RUN.
REQ-021 In STOP: a start event SHALL move to RUN (resume without clearing); a lap event SHALL move to IDLE and pulse o_countinit.
REQ-022 When start and lap events occur in the same cycle, the start event SHALL win and the lap event SHALL be discarded.
REQ-023 o_countenb and o_latchcount SHALL be registered and SHALL be 1 exactly when the state is RUN or LAP.
REQ-024 o_countinit SHALL be registered, high for exactly one cycle, coincident with the state update.
REQ-025 o_display SHALL equal the lap register when the state is LAP, and i_count otherwise (combinational mux).
REQ-026 o_lap_valid SHALL be 1 exactly when the state is LAP.
REQ-027 The lap register SHALL load only on a RUN-to-LAP transition.
REQ-028 Counter rollover at 59:59.99 SHALL be transparent: the block neither stops nor flags it.

Reset
REQ-029 rst SHALL immediately force IDLE, o_countenb=0, o_latchcount=0, o_countinit=0, o_lap_valid=0, o_state=2'b00, and clear the lap register, synchronizers, debounce counters and debounced levels to 0.
REQ-030 With rst asserted, o_display SHALL equal i_count.
REQ-031 rst SHALL NOT pulse o_countinit; the counter is cleared by its own reset.
REQ-032 A button held across reset release SHALL be seen as a fresh press and SHALL generate one event after the REQ-016 latency.
REQ-033 rst asserted mid-debounce or in RUN/LAP SHALL discard any pending event.

Verification
REQ-034 Reset, then hold i_startstop for 10 cycles -> o_state 00->01 and o_latchcount 0->1, both on edge 7 (DEBOUNCE_TICKS=4).
REQ-035 In RUN, bounce i_startstop 1-0-1-0 with 1-cycle pulses -> no state change and o_latchcount stays 1.
REQ-036 In RUN with i_count=24'h012345, press lap -> o_state=10, o_display=24'h012345 held while i_count advances, o_lap_valid=1; press lap again -> o_state=01, o_display tracks i_count.
REQ-037 RUN -> start -> STOP -> lap -> o_state=00 and o_countinit high for exactly 1 cycle; in IDLE press lap -> o_countinit pulses again and o_state stays 00.
REQ-038 In RUN, press both buttons on the same cycle -> o_state=11 (STOP), no lap capture, o_lap_valid=0.
REQ-039 Assert rst asynchronously mid-cycle in LAP -> all outputs 0 and o_display=i_count before the next clock edge, with no o_countinit pulse.
